// File: rtl/npc_seq_unit.sv
// npc_seq_unit: owns the PC register of the multi-cycle MIPS core and computes/commits its next value,
// including branch-delay-slot sequencing, EPC/BD/EXL exception state and misaligned-JR detection.
module npc_seq_unit #(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180,
    parameter bit              DELAY_SLOT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_we_i,
    input  logic [2:0]        npc_op_i,
    input  logic              br_taken_i,
    input  logic [25:0]       imm_i,
    input  logic [ADDR_W-1:0] rs_val_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [ADDR_W-1:0] npc_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic              bd_o,
    output logic              exl_o,
    output logic              in_slot_o,
    output logic              addr_err_o,
    output logic [ADDR_W-1:0] badvaddr_o
);
    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    typedef enum logic {SEQ, SLOT} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q, epc_q, target_q, badvaddr_q;
    logic              bd_q, exl_q, addr_err_q;

    logic [ADDR_W-1:0] p4, br, jmp, redir, pc_d;
    logic              is_br, is_j, is_jr, is_exc, is_eret, jr_bad, exc, taken, slot;

    always_comb begin
        p4      = pc_q + FOUR;
        br      = p4 + {{(ADDR_W-18){imm_i[15]}}, imm_i[15:0], 2'b00};
        jmp     = {p4[ADDR_W-1:28], imm_i, 2'b00};
        is_br   = npc_op_i == 3'd1;
        is_j    = npc_op_i == 3'd2;
        is_jr   = npc_op_i == 3'd3;
        is_exc  = npc_op_i == 3'd4;
        is_eret = npc_op_i == 3'd5;
        jr_bad  = is_jr & (rs_val_i[1:0] != 2'b00);
        exc     = is_exc | jr_bad;
        taken   = (is_br & br_taken_i) | is_j | (is_jr & ~jr_bad);
        redir   = is_j ? jmp : is_jr ? rs_val_i : br;
        slot    = state_q == SLOT;
        // Exceptions and ERET pre-empt a pending delay-slot redirect.
        pc_d    = exc ? EXC_VEC :
                  is_eret ? epc_q :
                  slot ? target_q :
                  (taken && !DELAY_SLOT) ? redir : p4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SEQ;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            target_q   <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            exl_q      <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= pc_we_i & jr_bad;
            if (pc_we_i) begin
                pc_q <= pc_d;
                if (jr_bad)
                    badvaddr_q <= rs_val_i;
                if (exc) begin
                    exl_q <= 1'b1;
                    if (!exl_q) begin
                        epc_q <= slot ? pc_q - FOUR : pc_q;
                        bd_q  <= slot;
                    end
                end
                if (is_eret)
                    exl_q <= 1'b0;
                if (!slot && taken)
                    target_q <= redir;
                state_q <= (!slot && taken && DELAY_SLOT) ? SLOT : SEQ;
            end
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = p4;
    assign npc_o      = pc_d;
    assign epc_o      = epc_q;
    assign bd_o       = bd_q;
    assign exl_o      = exl_q;
    assign in_slot_o  = slot;
    assign addr_err_o = addr_err_q;
    assign badvaddr_o = badvaddr_q;
endmodule

// File: tb/tb_npc_seq_unit.sv
// tb_npc_seq_unit: drives identical stimulus into a delay-slot and a no-delay-slot instance and
// compares both against an architectural next-PC model, plus directed scenario checks.
module tb_npc_seq_unit;
    logic        clk = 1'b0;
    logic        rst_n, pc_we, br_taken;
    logic [2:0]  npc_op;
    logic [25:0] imm;
    logic [31:0] rs_val;
    logic [31:0] pc [2], pc_plus4 [2], npc [2], epc [2], badvaddr [2];
    logic        bd [2], exl [2], in_slot [2], addr_err [2];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    npc_seq_unit #(.DELAY_SLOT(1'b0)) u_ds0 (
        .clk(clk), .rst_n(rst_n), .pc_we_i(pc_we), .npc_op_i(npc_op), .br_taken_i(br_taken),
        .imm_i(imm), .rs_val_i(rs_val), .pc_o(pc[0]), .pc_plus4_o(pc_plus4[0]), .npc_o(npc[0]),
        .epc_o(epc[0]), .bd_o(bd[0]), .exl_o(exl[0]), .in_slot_o(in_slot[0]),
        .addr_err_o(addr_err[0]), .badvaddr_o(badvaddr[0])
    );

    npc_seq_unit #(.DELAY_SLOT(1'b1)) u_ds1 (
        .clk(clk), .rst_n(rst_n), .pc_we_i(pc_we), .npc_op_i(npc_op), .br_taken_i(br_taken),
        .imm_i(imm), .rs_val_i(rs_val), .pc_o(pc[1]), .pc_plus4_o(pc_plus4[1]), .npc_o(npc[1]),
        .epc_o(epc[1]), .bd_o(bd[1]), .exl_o(exl[1]), .in_slot_o(in_slot[1]),
        .addr_err_o(addr_err[1]), .badvaddr_o(badvaddr[1])
    );

    typedef struct {
        logic [31:0] pc, epc, tgt, bad;
        bit          bd, exl, slot, aerr;
    } st_t;

    st_t m [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic st_t reset_state();
        st_t s;
        s.pc = 32'h3000; s.epc = 0; s.tgt = 0; s.bad = 0;
        s.bd = 0; s.exl = 0; s.slot = 0; s.aerr = 0;
        return s;
    endfunction

    // Architectural effect of one committed instruction (pc_we=1).
    function automatic st_t commit(st_t s, bit ds, logic [2:0] op, bit tk, logic [25:0] im, logic [31:0] rs);
        st_t n = s;
        logic [31:0] p4 = s.pc + 4;
        int signed   off = $signed(im[15:0]) * 4;
        logic [31:0] br = p4 + 32'(off);
        logic [31:0] jmp = {p4[31:28], im, 2'b00};
        bit misal = (op == 3) && (rs % 4 != 0);
        bit exc = (op == 4) || misal;
        bit redir = (op == 1 && tk) || op == 2 || (op == 3 && !misal);
        logic [31:0] dest = (op == 2) ? jmp : (op == 3) ? rs : br;
        n.aerr = misal;
        if (misal) n.bad = rs;
        n.slot = 0;
        if (exc) begin
            if (!s.exl) begin
                n.epc = s.slot ? s.pc - 4 : s.pc;
                n.bd = s.slot;
            end
            n.exl = 1;
            n.pc = 32'h4180;
        end else if (op == 5) begin
            n.pc = s.epc;
            n.exl = 0;
        end else if (s.slot) begin
            n.pc = s.tgt;
        end else if (redir && ds) begin
            n.pc = p4;
            n.tgt = dest;
            n.slot = 1;
        end else begin
            n.pc = redir ? dest : p4;
        end
        return n;
    endfunction

    task automatic step(input bit rn, input bit we, input logic [2:0] op, input bit tk,
                        input logic [25:0] im, input logic [31:0] rs);
        @(negedge clk);
        rst_n = rn; pc_we = we; npc_op = op; br_taken = tk; imm = im; rs_val = rs;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("npc%0d", k), npc[k], commit(m[k], k[0], op, tk, im, rs).pc);
            chk($sformatf("pc_plus4_%0d", k), pc_plus4[k], m[k].pc + 4);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rn) m[k] = reset_state();
            else if (we) m[k] = commit(m[k], k[0], op, tk, im, rs);
            else m[k].aerr = 0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pc%0d", k), pc[k], m[k].pc);
            chk($sformatf("epc%0d", k), epc[k], m[k].epc);
            chk($sformatf("bd%0d", k), 32'(bd[k]), 32'(m[k].bd));
            chk($sformatf("exl%0d", k), 32'(exl[k]), 32'(m[k].exl));
            chk($sformatf("in_slot%0d", k), 32'(in_slot[k]), 32'(m[k].slot));
            chk($sformatf("addr_err%0d", k), 32'(addr_err[k]), 32'(m[k].aerr));
            chk($sformatf("badvaddr%0d", k), badvaddr[k], m[k].bad);
        end
    endtask

    task automatic plus4();
        step(1, 1, 3'd0, 0, 26'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(0, 0, 3'd0, 0, 26'd0, 32'd0);
    endtask

    initial begin
        rst_n = 0; pc_we = 0; npc_op = 0; br_taken = 0; imm = 0; rs_val = 0;
        m[0] = reset_state(); m[1] = reset_state();
        do_reset();
        chk("t1_reset_pc", pc[1], 32'h3000);
        plus4(); chk("t1_pc1", pc[1], 32'h3004);
        plus4(); chk("t1_pc2", pc[1], 32'h3008);
        plus4(); chk("t1_pc3", pc[1], 32'h300C);
        step(1, 0, 3'd2, 1, 26'h3FF_FFFF, 32'd0);
        chk("t1_hold", pc[1], 32'h300C);
        plus4();
        step(1, 1, 3'd1, 1, 26'h000_FFFC, 32'd0);
        chk("t2_slot_pc", pc[1], 32'h3014);
        chk("t2_in_slot", 32'(in_slot[1]), 32'd1);
        chk("t2_ds0_pc", pc[0], 32'h3004);
        step(1, 1, 3'd4, 0, 26'd0, 32'd0);
        chk("t4_exc_pc", pc[1], 32'h4180);
        chk("t4_epc", epc[1], 32'h3010);
        chk("t4_bd", 32'(bd[1]), 32'd1);
        chk("t4_exl", 32'(exl[1]), 32'd1);
        step(1, 1, 3'd4, 0, 26'd0, 32'd0);
        chk("t4_epc_kept", epc[1], 32'h3010);
        step(1, 1, 3'd5, 0, 26'd0, 32'd0);
        chk("t4_eret_pc", pc[1], 32'h3010);
        chk("t4_eret_exl", 32'(exl[1]), 32'd0);
        step(1, 1, 3'd1, 1, 26'h000_FFFC, 32'd0);
        plus4();
        chk("t2_redirect", pc[1], 32'h3004);
        chk("t2_slot_clear", 32'(in_slot[1]), 32'd0);
        do_reset();
        step(1, 1, 3'd2, 0, 26'h000_0C10, 32'd0);
        chk("t3_ds0_jump", pc[0], 32'h3040);
        chk("t3_ds1_slot", pc[1], 32'h3004);
        plus4();
        chk("t3_ds1_jump", pc[1], 32'h3040);
        do_reset();
        plus4();
        step(1, 1, 3'd3, 0, 26'd0, 32'h0000_3006);
        chk("t5_pc", pc[1], 32'h4180);
        chk("t5_addr_err", 32'(addr_err[1]), 32'd1);
        chk("t5_badvaddr", badvaddr[1], 32'h3006);
        chk("t5_epc", epc[1], 32'h3004);
        step(1, 0, 3'd0, 0, 26'd0, 32'd0);
        chk("t5_addr_err_drop", 32'(addr_err[1]), 32'd0);
        do_reset();
        step(1, 1, 3'd2, 0, 26'h000_0C10, 32'd0);
        do_reset();
        chk("t6_pc", pc[1], 32'h3000);
        chk("t6_in_slot", 32'(in_slot[1]), 32'd0);
        plus4();
        chk("t6_no_stale", pc[1], 32'h3004);
        step(1, 1, 3'd3, 0, 26'd0, 32'hFFFF_FFFC);
        plus4();
        plus4();
        chk("wrap_ds1", pc[1], 32'h0000_0000);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rs = $urandom;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 1'($urandom), 26'($urandom), rs);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
